// File: rtl/data_memory.sv
// Multi-cycle little-endian data memory for the RV32IM memory stage.
// Fixed-latency byte/half/word accesses with BUSYWAIT stalling and load extension.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  MEM_FUNCT3,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MEM_ERROR
);

    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int ADDR_W = IDX_W + 2;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [2:0]         funct3_q;
    logic               is_write_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               req_s;
    logic               legal_s;
    logic               commit_s;
    logic               mem_we_s;
    logic [3:0]         mem_be_s;
    logic [31:0]        mem_lanes_s;
    logic [31:0]        mem_word_s;
    logic [31:0]        read_data_d;
    logic               unused_addr_s;

    function automatic logic access_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (rd) begin
            case (f3)
                3'b000, 3'b100: ok = 1'b1;
                3'b001, 3'b101: ok = ~a[0];
                3'b010:         ok = (a == 2'b00);
                default:        ok = 1'b0;
            endcase
        end else if (wr) begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = ~a[0];
                3'b010:  ok = (a == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << a;
            3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] l;
        case (f3)
            3'b000:  l = {4{wd[7:0]}};
            3'b001:  l = {2{wd[15:0]}};
            default: l = wd;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [31:0] s;
        logic [31:0] r;
        s = w >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'h000000, s[7:0]};
            3'b101:  r = {16'h0000, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Request decode and commit-cycle datapath from the latched request.
    always_comb begin
        req_s         = MEM_READ | MEM_WRITE;
        legal_s       = access_legal(MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS[1:0]);
        commit_s      = (state_q == ST_ACCESS) && (cnt_q == {CNT_W{1'b0}});
        mem_we_s      = commit_s && is_write_q && !RESET;
        mem_be_s      = store_be(funct3_q, addr_q[1:0]);
        mem_lanes_s   = store_lanes(funct3_q, wdata_q);
        mem_word_s    = mem_q[addr_q[ADDR_W-1:2]];
        read_data_d   = load_extract(funct3_q, addr_q[1:0], mem_word_s);
        unused_addr_s = ^MEM_ADDRESS[31:ADDR_W];
    end

    // Stall request; high while a request waits in IDLE or is in flight.
    assign BUSYWAIT = ~RESET & (((state_q == ST_IDLE) & req_s) | (state_q == ST_ACCESS));

    // Control FSM with latched request and registered result outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= 32'h0000_0000;
            funct3_q   <= 3'b000;
            is_write_q <= 1'b0;
            READ_DATA  <= 32'h0000_0000;
            MEM_ERROR  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    MEM_ERROR <= 1'b0;
                    if (req_s && legal_s) begin
                        addr_q     <= MEM_ADDRESS[ADDR_W-1:0];
                        wdata_q    <= MEM_WRITE_DATA;
                        funct3_q   <= MEM_FUNCT3;
                        is_write_q <= MEM_WRITE;
                        cnt_q      <= CNT_W'(LATENCY - 1);
                        state_q    <= ST_ACCESS;
                    end else if (req_s) begin
                        // Illegal request skips the array and reports in DONE.
                        READ_DATA <= 32'h0000_0000;
                        MEM_ERROR <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        if (!is_write_q) begin
                            READ_DATA <= read_data_d;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    MEM_ERROR <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    MEM_ERROR <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane store commit on the final ACCESS cycle; array has no reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_s[b]) begin
                    mem_q[addr_q[ADDR_W-1:2]][8*b +: 8] <= mem_lanes_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH_WORDS=256, LATENCY=4).
module tb_data_memory;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MEM_ERROR;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    logic [31:0] res_data;
    logic        res_err;
    int          res_busy;
    int          res_cyc;
    int          first_done;

    data_memory #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_FUNCT3     (MEM_FUNCT3),
        .MEM_ADDRESS    (MEM_ADDRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .READ_DATA      (READ_DATA),
        .BUSYWAIT       (BUSYWAIT),
        .MEM_ERROR      (MEM_ERROR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle just after a falling edge; returns in the following IDLE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        MEM_READ       = rd;
        MEM_WRITE      = wr;
        MEM_FUNCT3     = f3;
        MEM_ADDRESS    = addr;
        MEM_WRITE_DATA = wd;
        #1;
        res_busy = 0;
        while (BUSYWAIT && res_busy < 50) begin
            res_busy++;
            @(negedge CLK);
            #1;
        end
        res_data  = READ_DATA;
        res_err   = MEM_ERROR;
        res_cyc   = cyc;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        @(negedge CLK);
    endtask

    task automatic expect_access(input string tag, input int busy, input logic err,
                                 input logic [31:0] data);
        check_eq({tag, ".busy"}, 32'(res_busy), 32'(busy));
        check_eq({tag, ".err"}, {31'd0, res_err}, {31'd0, err});
        check_eq({tag, ".data"}, res_data, data);
    endtask

    initial begin
        RESET          = 1'b1;
        MEM_READ       = 1'b1;
        MEM_WRITE      = 1'b0;
        MEM_FUNCT3     = 3'b010;
        MEM_ADDRESS    = 32'h0000_0000;
        MEM_WRITE_DATA = 32'h0000_0000;
        repeat (3) @(negedge CLK);
        #1;
        check_eq("rst.busy", {31'd0, BUSYWAIT}, 32'd0);
        check_eq("rst.rdata", READ_DATA, 32'h0000_0000);
        check_eq("rst.err", {31'd0, MEM_ERROR}, 32'd0);
        MEM_READ = 1'b0;
        RESET    = 1'b0;
        @(negedge CLK);

        // Word round trip
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        expect_access("sw10", 5, 1'b0, 32'h0000_0000);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        expect_access("lw10", 5, 1'b0, 32'hDEAD_BEEF);

        // Byte lanes; store leaves READ_DATA untouched
        do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0000_0000);
        expect_access("sw20", 5, 1'b0, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b1, 3'b000, 32'h23, 32'h0000_0080);
        check_eq("sb23.err", {31'd0, res_err}, 32'd0);
        do_access(1'b1, 1'b0, 3'b000, 32'h23, 32'h0);
        expect_access("lb23", 5, 1'b0, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h23, 32'h0);
        check_eq("lbu23", res_data, 32'h0000_0080);
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        check_eq("lw20", res_data, 32'h8000_0000);

        // Halfword
        do_access(1'b0, 1'b1, 3'b010, 32'h30, 32'h0000_0000);
        do_access(1'b0, 1'b1, 3'b001, 32'h32, 32'h1234_F00D);
        check_eq("sh32.err", {31'd0, res_err}, 32'd0);
        do_access(1'b1, 1'b0, 3'b001, 32'h32, 32'h0);
        check_eq("lh32", res_data, 32'hFFFF_F00D);
        do_access(1'b1, 1'b0, 3'b101, 32'h32, 32'h0);
        check_eq("lhu32", res_data, 32'h0000_F00D);
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        check_eq("lw30", res_data, 32'hF00D_0000);

        // Illegal requests
        do_access(1'b1, 1'b0, 3'b010, 32'h41, 32'h0);
        expect_access("lw41", 1, 1'b1, 32'h0000_0000);
        check_eq("err.pulse", {31'd0, MEM_ERROR}, 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        check_eq("lw30b", res_data, 32'hF00D_0000);
        do_access(1'b1, 1'b1, 3'b010, 32'h30, 32'hFFFF_FFFF);
        expect_access("rdwr", 1, 1'b1, 32'h0000_0000);
        do_access(1'b0, 1'b1, 3'b100, 32'h30, 32'hFFFF_FFFF);
        expect_access("badsf3", 1, 1'b1, 32'h0000_0000);
        do_access(1'b1, 1'b0, 3'b110, 32'h30, 32'h0);
        expect_access("badlf3", 1, 1'b1, 32'h0000_0000);
        do_access(1'b1, 1'b0, 3'b001, 32'h33, 32'h0);
        expect_access("lh33", 1, 1'b1, 32'h0000_0000);
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        check_eq("lw30c", res_data, 32'hF00D_0000);

        // Reset during the second ACCESS cycle of a store
        do_access(1'b0, 1'b1, 3'b010, 32'h50, 32'h1111_1111);
        do_access(1'b1, 1'b0, 3'b010, 32'h50, 32'h0);
        check_eq("lw50a", res_data, 32'h1111_1111);
        MEM_READ       = 1'b0;
        MEM_WRITE      = 1'b1;
        MEM_FUNCT3     = 3'b010;
        MEM_ADDRESS    = 32'h50;
        MEM_WRITE_DATA = 32'hAAAA_AAAA;
        @(negedge CLK);
        @(negedge CLK);
        RESET     = 1'b1;
        MEM_WRITE = 1'b0;
        #1;
        check_eq("rstmid.busy", {31'd0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_eq("rstpost.busy", {31'd0, BUSYWAIT}, 32'd0);
        check_eq("rstpost.rdata", READ_DATA, 32'h0000_0000);
        @(negedge CLK);
        do_access(1'b1, 1'b0, 3'b010, 32'h50, 32'h0);
        expect_access("lw50b", 5, 1'b0, 32'h1111_1111);

        // Address wrap and back-to-back timing
        do_access(1'b0, 1'b1, 3'b010, 32'h404, 32'h5A5A_5A5A);
        first_done = res_cyc;
        do_access(1'b1, 1'b0, 3'b010, 32'h004, 32'h0);
        expect_access("lw004", 5, 1'b0, 32'h5A5A_5A5A);
        check_eq("b2b.gap", 32'(res_cyc - first_done), 32'd6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
